gray_fifo_ptr: RTL
==================

Name: gray_fifo_ptr

Overview:
Parametrised gray-coded FIFO pointer with registered full/empty, fill-level and almost flags, one instance per side of an async FIFO. It owns the local binary/gray pointer and the RAM address. It compares the local pointer against the remote gray pointer, which has already been synchronised into this domain. Width is set by AddrWidth instead of the fixed 32-bit word_t, and the conversions are generic over AddrWidth+1 bits.

Parameters:
AddrWidth, 4, RAM address bits; pointer width PW = AddrWidth+1, depth D = 2**AddrWidth
IsWrite, 1, 1 = write side (flag_o means full), 0 = read side (flag_o means empty)
AlmostThresh, 2, almost-flag margin in entries, 0..D

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
inc_i  in  1  request to advance pointer (push on write side, pop on read side)
remote_gray_i  in  PW  synchronised gray pointer of opposite side
addr_o  out  AddrWidth  RAM address = ptr_bin_o[AddrWidth-1:0]
ptr_bin_o  out  PW  local binary pointer (registered)
ptr_gray_o  out  PW  local gray pointer (registered, exported to the other domain)
flag_o  out  1  full (IsWrite=1) / empty (IsWrite=0), registered
almost_o  out  1  almost-full / almost-empty, registered
level_o  out  PW  occupancy as seen from this side, 0..D, registered

Behaviour:
- Reset (rst_i sampled high at clk edge):
  - ptr_bin_o=0, ptr_gray_o=0, addr_o=0, level_o=0.
  - flag_o=0 on the write side, 1 on the read side.
  - almost_o: write side = (0 >= D-AlmostThresh); read side = 1.
  - Reset wins over inc_i in the same cycle.
  - Mid-operation reset discards all state; no partial increment.
- Accept: acc = inc_i & ~flag_o.
  - inc_i while flag_o=1 is ignored; pointer and flags hold unless remote changes.
- Next pointer:
  - bin_n = acc ? ptr_bin_o+1 : ptr_bin_o, modulo 2**PW (wraps 2**PW-1 -> 0).
  - gray_n = bin_n ^ (bin_n >> 1).
  - Both are registered. ptr_gray_o comes straight from a flop, never from a combinational path, so exactly one bit toggles per accepted increment, including across wrap.
- Remote conversion: rbin = gray-to-binary of remote_gray_i. Bit i = XOR of remote_gray_i[PW-1:i]. Generic prefix-XOR for any PW, combinational.
- Level, registered, 1-cycle latency from acc or a remote change, subtraction modulo 2**PW:
  - Write side: level_o <= bin_n - rbin.
  - Read side: level_o <= rbin - bin_n.
- Flags, registered from next pointer and current remote:
  - Write: flag_o <= (gray_n == {~remote_gray_i[PW-1:PW-2], remote_gray_i[PW-3:0]}). For AddrWidth=1 only the top two bits are inverted.
  - Read: flag_o <= (gray_n == remote_gray_i).
  - Flags assert on the edge of the accepting push/pop itself, so no over-run is possible.
- Almost, registered:
  - Write: almost_o <= (level_n >= D-AlmostThresh).
  - Read: almost_o <= (level_n <= AlmostThresh).
  - level_n is the same value loaded into level_o.
- Simultaneous acc and remote change: both are applied in the same cycle's computation.
- Flag deassertion is pessimistic and follows remote updates only. Remote staleness is the synchroniser's concern.
- A remote pointer implying level > D is illegal; the bench asserts it never occurs, and the output is unspecified.

Test Plan:
- Reset: hold rst_i 2 cycles with inc_i=1, both modes -> pointers 0, level 0. Write flag_o=0, almost_o=0. Read flag_o=1, almost_o=1.
- Write fill, AddrWidth=4, remote_gray_i=0, inc_i=1 for 17 cycles:
  - flag_o rises on the edge of the 16th accept; level_o=16; ptr_bin_o=16; ptr_gray_o=5'b11000.
  - 17th request is ignored; pointer stays 16.
  - almost_o=1 from level 14 onward.
- Read drain, IsWrite=0: set remote_gray_i=gray(3)=5'b00010 -> next cycle flag_o=0, level_o=3. Three pops -> flag_o=1, ptr_bin_o=3, almost_o=1 from level 2 onward.
- Wrap, write side: 40 accepted increments with remote tracking ptr_gray_o one cycle late -> ptr_bin_o wraps 31->0. Check every gray step has Hamming distance 1, including 5'b10000 -> 5'b00000, and flag_o is never set.
- Simultaneous events, write side at level 16 (full): in one cycle inc_i=1 and the remote advances by one -> push ignored that cycle. Next cycle flag_o=0, level_o=15. Following inc_i is accepted.
- Reset mid-fill: at level 9, assert rst_i together with inc_i=1 -> next cycle all outputs at reset values. Then 16 pushes are needed to reach full.

Source files
------------

// File: rtl/gray_fifo_ptr.sv
// One side of an async FIFO: local binary/gray pointer, RAM address, and registered
// full-or-empty, almost and fill-level flags against the synchronised remote gray pointer.
module gray_fifo_ptr #(
   parameter int unsigned AddrWidth    = 4,
   parameter bit          IsWrite      = 1'b1,
   parameter int unsigned AlmostThresh = 2,
   localparam int unsigned PW          = AddrWidth + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   input  logic [PW-1:0]        remote_gray_i,
   output logic [AddrWidth-1:0] addr_o,
   output logic [PW-1:0]        ptr_bin_o,
   output logic [PW-1:0]        ptr_gray_o,
   output logic                 flag_o,
   output logic                 almost_o,
   output logic [PW-1:0]        level_o
);

   localparam int unsigned Depth = 2 ** AddrWidth;
   // Full when the local gray equals the remote gray with its two MSBs inverted.
   localparam logic [PW-1:0] FullMask       = PW'(3) << (PW - 2);
   localparam logic [PW-1:0] AlmostFullLvl  = PW'(Depth - AlmostThresh);
   localparam logic [PW-1:0] AlmostEmptyLvl = PW'(AlmostThresh);
   localparam logic          RstFlag        = !IsWrite;
   localparam logic          RstAlmost      = IsWrite ? (AlmostThresh >= Depth) : 1'b1;

   logic [PW-1:0] ptr_bin_q, ptr_bin_d;
   logic [PW-1:0] ptr_gray_q, ptr_gray_d;
   logic [PW-1:0] level_q, level_d;
   logic          flag_q, flag_d;
   logic          almost_q, almost_d;
   logic          acc;
   logic [PW-1:0] rbin;

   // Next pointer, remote conversion, and next-state flags.
   always_comb begin
      acc        = 1'b0;
      rbin       = '0;
      ptr_bin_d  = ptr_bin_q;
      ptr_gray_d = ptr_gray_q;
      level_d    = level_q;
      flag_d     = flag_q;
      almost_d   = almost_q;

      acc        = inc_i & ~flag_q;
      ptr_bin_d  = ptr_bin_q + PW'(acc);
      ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);

      // Gray-to-binary: each bit is the XOR of all gray bits at or above it.
      for (int i = 0; i < int'(PW); i++) begin
         rbin[i] = ^(remote_gray_i >> i);
      end

      if (IsWrite) begin
         level_d  = ptr_bin_d - rbin;
         flag_d   = (ptr_gray_d == (remote_gray_i ^ FullMask));
         almost_d = (level_d >= AlmostFullLvl);
      end else begin
         level_d  = rbin - ptr_bin_d;
         flag_d   = (ptr_gray_d == remote_gray_i);
         almost_d = (level_d <= AlmostEmptyLvl);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_bin_q  <= '0;
         ptr_gray_q <= '0;
         level_q    <= '0;
         flag_q     <= RstFlag;
         almost_q   <= RstAlmost;
      end else begin
         ptr_bin_q  <= ptr_bin_d;
         ptr_gray_q <= ptr_gray_d;
         level_q    <= level_d;
         flag_q     <= flag_d;
         almost_q   <= almost_d;
      end
   end

   assign addr_o     = ptr_bin_q[AddrWidth-1:0];
   assign ptr_bin_o  = ptr_bin_q;
   assign ptr_gray_o = ptr_gray_q;
   assign flag_o     = flag_q;
   assign almost_o   = almost_q;
   assign level_o    = level_q;

endmodule
